// File: rtl/button_bank_if.sv
// Button bank signal bundle: raw pins in, filtered levels and event pulses out.
// The controller side uses master, the button_bank instance uses slave.
interface button_bank_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] noisy;
  logic [N_CH-1:0] debounced;
  logic [N_CH-1:0] p_edge;
  logic [N_CH-1:0] n_edge;
  logic [N_CH-1:0] _edge;
  logic [N_CH-1:0] long_press;
  logic [N_CH-1:0] held;
  logic [N_CH-1:0] repeat_tick;
  logic            any_pressed;

  modport master (
    output noisy,
    input  debounced, p_edge, n_edge, _edge, long_press, held, repeat_tick, any_pressed
  );

  modport slave (
    input  noisy,
    output debounced, p_edge, n_edge, _edge, long_press, held, repeat_tick, any_pressed
  );
endinterface

// File: rtl/button_bank.sv
// N_CH-channel button conditioner: synchroniser, debounce filter, press/release pulses,
// long-press detection and auto-repeat ticks per channel.
module button_bank #(
  parameter int              N_CH          = 4,
  parameter int              STABLE_CYCLES = 2_000_000,
  parameter int              LONG_CYCLES   = 100_000_000,
  parameter int              REPEAT_CYCLES = 20_000_000,
  parameter logic [N_CH-1:0] ACTIVE_LOW    = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  button_bank_if.slave bus
);

  localparam int DEB_W  = $clog2(STABLE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam int REP_W  = (REPEAT_CYCLES < 2) ? 1 : $clog2(REPEAT_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_HELD
  } state_t;

  logic [N_CH-1:0] deb_v;
  logic [N_CH-1:0] pe_v;
  logic [N_CH-1:0] ne_v;
  logic [N_CH-1:0] long_v;
  logic [N_CH-1:0] held_v;
  logic [N_CH-1:0] tick_v;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic              sync1_q;
    logic              sync2_q;
    logic              deb_q;
    logic              pe_q;
    logic              ne_q;
    logic              long_q;
    logic              held_q;
    logic              tick_q;
    logic [DEB_W-1:0]  deb_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [REP_W-1:0]  rep_cnt_q;
    state_t            state_q;
    logic              raw_s;
    logic              flip_d;

    // Polarity is corrected after the synchroniser so the flops idle at the pin's rest level.
    assign raw_s  = sync2_q ^ ACTIVE_LOW[gi];
    assign flip_d = (raw_s != deb_q) && (deb_cnt_q == DEB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= ACTIVE_LOW[gi];
        sync2_q <= ACTIVE_LOW[gi];
      end else begin
        sync1_q <= bus.noisy[gi];
        sync2_q <= sync1_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb_q     <= 1'b0;
        deb_cnt_q <= '0;
        pe_q      <= 1'b0;
        ne_q      <= 1'b0;
      end else begin
        pe_q <= flip_d & ~deb_q;
        ne_q <= flip_d & deb_q;
        if (raw_s == deb_q) begin
          deb_cnt_q <= '0;
        end else if (flip_d) begin
          deb_q     <= ~deb_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + 1'b1;
        end
      end
    end

    // Release overrides every state so held drops in the same cycle n_edge shows.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= ST_IDLE;
        hold_cnt_q <= '0;
        rep_cnt_q  <= '0;
        long_q     <= 1'b0;
        held_q     <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        long_q <= 1'b0;
        tick_q <= 1'b0;
        if (flip_d && deb_q) begin
          state_q    <= ST_IDLE;
          hold_cnt_q <= '0;
          rep_cnt_q  <= '0;
          held_q     <= 1'b0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (flip_d) begin
                state_q    <= ST_PRESSED;
                hold_cnt_q <= '0;
              end
            end
            ST_PRESSED: begin
              if (hold_cnt_q == HOLD_LAST) begin
                state_q   <= ST_HELD;
                long_q    <= 1'b1;
                held_q    <= 1'b1;
                rep_cnt_q <= '0;
              end else begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
              end
            end
            ST_HELD: begin
              if (REPEAT_CYCLES != 0) begin
                if (rep_cnt_q == REP_LAST) begin
                  tick_q    <= 1'b1;
                  rep_cnt_q <= '0;
                end else begin
                  rep_cnt_q <= rep_cnt_q + 1'b1;
                end
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end

    assign deb_v[gi]  = deb_q;
    assign pe_v[gi]   = pe_q;
    assign ne_v[gi]   = ne_q;
    assign long_v[gi] = long_q;
    assign held_v[gi] = held_q;
    assign tick_v[gi] = tick_q;
  end

  assign bus.debounced   = deb_v;
  assign bus.p_edge      = pe_v;
  assign bus.n_edge      = ne_v;
  assign bus._edge       = pe_v | ne_v;
  assign bus.long_press  = long_v;
  assign bus.held        = held_v;
  assign bus.repeat_tick = tick_v;
  assign bus.any_pressed = |deb_v;

endmodule
